// File: rtl/debug_pkg.sv
// Shared command byte codes and FSM state encoding for the debug step controller.
package debug_pkg;

   localparam logic [7:0] CMD_STEP = 8'h53;
   localparam logic [7:0] CMD_RUN  = 8'h43;
   localparam logic [7:0] CMD_DUMP = 8'h44;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_STEP = 3'd1,
      ST_RUN  = 3'd2,
      ST_LOAD = 3'd3,
      ST_SEND = 3'd4
   } state_t;

endpackage

// File: rtl/word_serializer.sv
// Splits one NB-bit word into big-endian bytes over a valid/ready byte channel.
module word_serializer
   import debug_pkg::*;
#(
   parameter int unsigned NB = 32
) (
   input  logic          i_clk,
   input  logic          i_reset,
   input  logic          i_load,
   input  logic [NB-1:0] i_word,
   input  logic          i_tx_ready,
   output logic [7:0]    o_tx_data,
   output logic          o_tx_valid,
   output logic          o_last_byte_c
);

   localparam int unsigned N_BYTES = NB / 8;
   localparam int unsigned BC_W    = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;

   logic [NB-1:0]   sh;
   logic [NB-1:0]   sh_next;
   logic [BC_W-1:0] byte_cnt;
   logic            accept;

   assign sh_next       = sh << 8;
   assign accept        = o_tx_valid && i_tx_ready;
   assign o_last_byte_c = accept && (byte_cnt == BC_W'(N_BYTES - 1));

   // Data and valid only move on load or on an accepted byte, so a stall holds them.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         sh         <= '0;
         byte_cnt   <= '0;
         o_tx_data  <= '0;
         o_tx_valid <= 1'b0;
      end else if (i_load) begin
         sh         <= i_word;
         byte_cnt   <= '0;
         o_tx_data  <= i_word[NB-1 -: 8];
         o_tx_valid <= 1'b1;
      end else if (accept) begin
         sh <= sh_next;
         if (o_last_byte_c) begin
            o_tx_valid <= 1'b0;
         end else begin
            byte_cnt  <= byte_cnt + BC_W'(1);
            o_tx_data <= sh_next[NB-1 -: 8];
         end
      end
   end

endmodule

// File: rtl/debug_step_controller.sv
// Command decoder, pipeline step/run control and debug-word dump sequencer.
module debug_step_controller
   import debug_pkg::*;
#(
   parameter int unsigned NB      = 32,
   parameter int unsigned N_WORDS = 8,
   parameter int unsigned NB_IDX  = 3,
   parameter int unsigned MAX_RUN = 65535
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic [7:0]        i_rx_data,
   input  logic              i_rx_valid,
   input  logic              i_halt,
   input  logic [NB-1:0]     i_dump_word,
   input  logic              i_tx_ready,
   output logic              o_step,
   output logic [NB_IDX-1:0] o_dump_index,
   output logic [7:0]        o_tx_data,
   output logic              o_tx_valid,
   output logic              o_busy
);

   localparam int unsigned RUN_W = $clog2(MAX_RUN + 1);

   state_t            state_q, state_d;
   logic              step_d;
   logic [NB_IDX-1:0] idx_d;
   logic [RUN_W-1:0]  run_cnt_q, run_cnt_d;
   logic              last_byte_c;

   word_serializer #(.NB(NB)) u_ser (
      .i_clk         (i_clk),
      .i_reset       (i_reset),
      .i_load        (state_q == ST_LOAD),
      .i_word        (i_dump_word),
      .i_tx_ready    (i_tx_ready),
      .o_tx_data     (o_tx_data),
      .o_tx_valid    (o_tx_valid),
      .o_last_byte_c (last_byte_c)
   );

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q      <= ST_IDLE;
         o_step       <= 1'b0;
         o_dump_index <= '0;
         run_cnt_q    <= '0;
         o_busy       <= 1'b0;
      end else begin
         state_q      <= state_d;
         o_step       <= step_d;
         o_dump_index <= idx_d;
         run_cnt_q    <= run_cnt_d;
         o_busy       <= (state_d != ST_IDLE);
      end
   end

   // Next state; o_step is asserted for every cycle the next state is STEP or a continuing RUN.
   always_comb begin
      state_d   = state_q;
      step_d    = 1'b0;
      idx_d     = o_dump_index;
      run_cnt_d = run_cnt_q;
      case (state_q)
         ST_IDLE: begin
            run_cnt_d = '0;
            if (i_rx_valid) begin
               if ((i_rx_data == CMD_STEP || i_rx_data == CMD_RUN) && i_halt) begin
                  state_d = ST_LOAD;
               end else if (i_rx_data == CMD_STEP) begin
                  state_d = ST_STEP;
                  step_d  = 1'b1;
               end else if (i_rx_data == CMD_RUN) begin
                  state_d = ST_RUN;
                  step_d  = 1'b1;
               end else if (i_rx_data == CMD_DUMP) begin
                  state_d = ST_LOAD;
               end
            end
         end
         ST_STEP: state_d = ST_LOAD;
         ST_RUN: begin
            if (i_halt || run_cnt_q == RUN_W'(MAX_RUN - 1)) begin
               state_d = ST_LOAD;
            end else begin
               step_d    = 1'b1;
               run_cnt_d = run_cnt_q + RUN_W'(1);
            end
         end
         ST_LOAD: state_d = ST_SEND;
         ST_SEND: begin
            if (last_byte_c) begin
               if (o_dump_index == NB_IDX'(N_WORDS - 1)) begin
                  idx_d   = '0;
                  state_d = ST_IDLE;
               end else begin
                  idx_d   = o_dump_index + NB_IDX'(1);
                  state_d = ST_LOAD;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_debug_step_controller.sv
// Directed-plus-random bench for debug_step_controller against a byte-stream reference model.
module tb_debug_step_controller;

   localparam int unsigned NB      = 32;
   localparam int unsigned N_WORDS = 8;
   localparam int unsigned NB_IDX  = 3;
   localparam int unsigned MAX_RUN = 16;
   localparam int          DUMP_BYTES = N_WORDS * (NB / 8);

   logic              clk = 1'b0;
   logic              i_reset = 1'b1;
   logic [7:0]        i_rx_data = 8'h00;
   logic              i_rx_valid = 1'b0;
   logic              i_halt = 1'b0;
   logic [NB-1:0]     i_dump_word;
   logic              i_tx_ready = 1'b1;
   logic              o_step;
   logic [NB_IDX-1:0] o_dump_index;
   logic [7:0]        o_tx_data;
   logic              o_tx_valid;
   logic              o_busy;

   logic [NB-1:0] mem [N_WORDS];
   assign i_dump_word = mem[o_dump_index];

   debug_step_controller #(
      .NB(NB), .N_WORDS(N_WORDS), .NB_IDX(NB_IDX), .MAX_RUN(MAX_RUN)
   ) dut (
      .i_clk        (clk),
      .i_reset      (i_reset),
      .i_rx_data    (i_rx_data),
      .i_rx_valid   (i_rx_valid),
      .i_halt       (i_halt),
      .i_dump_word  (i_dump_word),
      .i_tx_ready   (i_tx_ready),
      .o_step       (o_step),
      .o_dump_index (o_dump_index),
      .o_tx_data    (o_tx_data),
      .o_tx_valid   (o_tx_valid),
      .o_busy       (o_busy)
   );

   always #5 clk = ~clk;

   int n_assert = 0;
   int n_fail   = 0;

   // Negedge monitor: logs bytes that the next posedge will accept, counts step cycles, checks stalls.
   logic [7:0] byte_log [512];
   int         byte_wr   = 0;
   int         step_cnt  = 0;
   int         stall_err = 0;
   logic       pend      = 1'b0;
   logic [7:0] pend_data = 8'h00;

   always @(negedge clk) begin
      if (i_reset) begin
         pend <= 1'b0;
      end else begin
         if (pend && !(o_tx_valid && o_tx_data == pend_data)) stall_err <= stall_err + 1;
         pend      <= o_tx_valid && !i_tx_ready;
         pend_data <= o_tx_data;
         if (o_tx_valid && i_tx_ready && byte_wr < 512) begin
            byte_log[byte_wr] <= o_tx_data;
            byte_wr           <= byte_wr + 1;
         end
         if (o_step) step_cnt <= step_cnt + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_cmd(input logic [7:0] b);
      i_rx_data  = b;
      i_rx_valid = 1'b1;
      tick();
      i_rx_valid = 1'b0;
   endtask

   task automatic fill_mem();
      for (int i = 0; i < N_WORDS; i++) mem[i] = $urandom;
   endtask

   // Reference: word n/4 of the dump, byte n%4 counted from the MSB.
   function automatic logic [7:0] exp_byte(input int n);
      logic [NB-1:0] w;
      w = mem[n / 4];
      return 8'(w >> (8 * (3 - (n % 4))));
   endfunction

   task automatic wait_idle(input string tag, input bit toggle);
      int n;
      n = 0;
      while (o_busy && n < 1000) begin
         tick();
         if (toggle) i_tx_ready = ~i_tx_ready;
         n++;
      end
      i_tx_ready = 1'b1;
      chk({tag, "_timeout"}, 32'(o_busy), 32'd0);
   endtask

   task automatic check_dump(input string tag, input int base, input int nbytes);
      chk({tag, "_len"}, 32'(byte_wr - base), 32'(nbytes));
      for (int i = 0; i < nbytes && base + i < byte_wr; i++)
         chk({tag, "_byte"}, 32'(byte_log[base + i]), 32'(exp_byte(i)));
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_step"}, 32'(o_step), 32'd0);
      chk({tag, "_idx"}, 32'(o_dump_index), 32'd0);
      chk({tag, "_txd"}, 32'(o_tx_data), 32'd0);
      chk({tag, "_txv"}, 32'(o_tx_valid), 32'd0);
      chk({tag, "_busy"}, 32'(o_busy), 32'd0);
   endtask

   initial begin
      int base, s0, d, n;
      fill_mem();
      repeat (3) tick();
      check_reset_outputs("reset");
      i_reset = 1'b0;
      tick();

      // Single step: one step cycle, first byte two edges after the strobe.
      base = byte_wr; s0 = step_cnt;
      send_cmd(8'h53);
      chk("s_step_hi", 32'(o_step), 32'd1);
      chk("s_busy", 32'(o_busy), 32'd1);
      tick();
      chk("s_step_lo", 32'(o_step), 32'd0);
      chk("s_txv_early", 32'(o_tx_valid), 32'd0);
      tick();
      chk("s_txv", 32'(o_tx_valid), 32'd1);
      chk("s_txd0", 32'(o_tx_data), 32'(exp_byte(0)));
      wait_idle("s", 1'b0);
      chk("s_steps", 32'(step_cnt - s0), 32'd1);
      check_dump("s_dump", base, DUMP_BYTES);
      chk("s_idx_end", 32'(o_dump_index), 32'd0);

      // Run with halt arriving ten cycles after the command.
      fill_mem();
      base = byte_wr; s0 = step_cnt;
      send_cmd(8'h43);
      repeat (9) tick();
      i_halt = 1'b1;
      tick();
      chk("c_step_after_halt", 32'(o_step), 32'd0);
      wait_idle("c", 1'b0);
      d = step_cnt - s0;
      chk("c_steps_10_11", 32'(d == 10 || d == 11), 32'd1);
      check_dump("c_dump", base, DUMP_BYTES);
      i_halt = 1'b0;

      // Dump with ready toggling every cycle.
      fill_mem();
      base = byte_wr; s0 = stall_err;
      send_cmd(8'h44);
      i_tx_ready = 1'b0;
      wait_idle("d", 1'b1);
      tick();
      chk("d_stall_stable", 32'(stall_err - s0), 32'd0);
      check_dump("d_dump", base, DUMP_BYTES);

      // Step while halted: no step pulse, dump still sent; unknown byte ignored.
      fill_mem();
      i_halt = 1'b1;
      base = byte_wr; s0 = step_cnt;
      send_cmd(8'h53);
      chk("sh_step", 32'(o_step), 32'd0);
      chk("sh_busy", 32'(o_busy), 32'd1);
      wait_idle("sh", 1'b0);
      chk("sh_steps", 32'(step_cnt - s0), 32'd0);
      check_dump("sh_dump", base, DUMP_BYTES);
      i_halt = 1'b0;
      send_cmd(8'h41);
      chk("bad_busy", 32'(o_busy), 32'd0);
      tick();
      chk("bad_busy2", 32'(o_busy), 32'd0);
      chk("bad_txv", 32'(o_tx_valid), 32'd0);
      chk("bad_step", 32'(o_step), 32'd0);

      // Mid-dump 'D' is dropped; reset after five bytes aborts; next 'D' starts at word 0.
      fill_mem();
      base = byte_wr;
      send_cmd(8'h44);
      n = 0;
      while (byte_wr - base < 2 && n < 200) begin tick(); n++; end
      send_cmd(8'h44);
      while (byte_wr - base < 5 && n < 200) begin tick(); n++; end
      chk("r_wait5", 32'(byte_wr - base), 32'd5);
      i_reset = 1'b1;
      tick();
      check_reset_outputs("r_abort");
      i_reset = 1'b0;
      tick();
      check_dump("r_partial", base, 5);
      base = byte_wr;
      send_cmd(8'h44);
      chk("r_idx0", 32'(o_dump_index), 32'd0);
      wait_idle("r", 1'b0);
      check_dump("r_dump", base, DUMP_BYTES);

      // Watchdog: halt never arrives, run stops after exactly MAX_RUN steps.
      fill_mem();
      base = byte_wr; s0 = step_cnt;
      send_cmd(8'h43);
      repeat (MAX_RUN - 1) tick();
      chk("w_step_last", 32'(o_step), 32'd1);
      tick();
      chk("w_step_off", 32'(o_step), 32'd0);
      wait_idle("w", 1'b0);
      chk("w_steps", 32'(step_cnt - s0), 32'(MAX_RUN));
      check_dump("w_dump", base, DUMP_BYTES);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
